// File: rtl/out_between_pkg.sv
// Shared types and defaults for the output-to-between FIFO sender.
package out_between_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Bits needed for a counter running 0..t-1 (at least one bit).
  function automatic int unsigned tmo_width(input int unsigned t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a combinational head read.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic [WIDTH-1:0]               head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a same-cycle pop never admits a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array carries no reset; contents are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/out_to_between_fifo.sv
// Buffered between-bus sender: four-phase tsent/trecieve handshake per word,
// per-word acknowledge timeout with sticky error, and a drain pulse.
module out_to_between_fifo
  import out_between_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            data,
  output logic                        full,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [WIDTH-1:0]            tdata,
  output logic                        tsent,
  input  logic                        trecieve,
  output logic                        isFinish,
  output logic                        errTimeout
);

  localparam int unsigned TW = tmo_width(TIMEOUT);

  state_t           state, state_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_nxt;
  logic             tsent_nxt;
  logic [WIDTH-1:0] tdata_nxt;
  logic             fin_nxt;
  logic             err_nxt;
  logic             pop_c;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_c;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wdata  (data),
    .pop    (pop_c),
    .full   (full),
    .empty  (fifo_empty),
    .count  (count),
    .head_c (head_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      tsent      <= 1'b0;
      tdata      <= '0;
      isFinish   <= 1'b0;
      errTimeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_nxt;
      tsent      <= tsent_nxt;
      tdata      <= tdata_nxt;
      isFinish   <= fin_nxt;
      errTimeout <= err_nxt;
    end
  end

  // Head word stays in the FIFO until it leaves SEND, so count includes it.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    tsent_nxt = tsent;
    tdata_nxt = tdata;
    fin_nxt   = 1'b0;
    err_nxt   = errTimeout;
    pop_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_SEND;
          tsent_nxt = 1'b1;
          tdata_nxt = head_c;
          tmo_nxt   = '0;
        end
      end
      ST_SEND: begin
        if (trecieve) begin
          state_nxt = ST_RELEASE;
          tsent_nxt = 1'b0;
          tdata_nxt = '0;
          pop_c     = 1'b1;
        end else if ((TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT - 1))) begin
          state_nxt = ST_RELEASE;
          tsent_nxt = 1'b0;
          tdata_nxt = '0;
          pop_c     = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      ST_RELEASE: begin
        if (!trecieve) begin
          state_nxt = ST_IDLE;
          fin_nxt   = (count == '0);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_out_to_between_fifo.sv
// Randomised and directed bench for out_to_between_fifo against a queue-based model.
module tb_out_to_between_fifo;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             trecieve = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             full;
  logic             tsent;
  logic             isFinish;
  logic             errTimeout;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] tdata;

  always #5 clk = ~clk;

  out_to_between_fifo #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .data       (data),
    .full       (full),
    .count      (count),
    .tdata      (tdata),
    .tsent      (tsent),
    .trecieve   (trecieve),
    .isFinish   (isFinish),
    .errTimeout (errTimeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: queue of words plus handshake phase
  // (0 = waiting for a word, 1 = word on bus, 2 = waiting for ack release).
  logic [WIDTH-1:0] mq[$];
  int               m_phase;
  int               m_wait;
  logic             m_tsent;
  logic [WIDTH-1:0] m_tdata;
  logic             m_fin;
  logic             m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_wait  = 0;
    m_tsent = 1'b0;
    m_tdata = '0;
    m_fin   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    bit do_pop   = 1'b0;
    bit was_full = (mq.size() == DEPTH);
    bit fin      = 1'b0;
    case (m_phase)
      0: if (mq.size() != 0) begin
        m_phase = 1;
        m_tsent = 1'b1;
        m_tdata = mq[0];
        m_wait  = 0;
      end
      1: if (trecieve) do_pop = 1'b1;
         else if (TIMEOUT != 0 && m_wait == int'(TIMEOUT) - 1) begin
           do_pop = 1'b1;
           m_err  = 1'b1;
         end else m_wait++;
      default: if (!trecieve) begin
        m_phase = 0;
        fin     = (mq.size() == 0);
      end
    endcase
    if (do_pop) begin
      void'(mq.pop_front());
      m_phase = 2;
      m_tsent = 1'b0;
      m_tdata = '0;
    end
    m_fin = fin;
    if (push && !was_full) mq.push_back(data);
  endtask

  task automatic check_all();
    chk("tsent", int'(tsent), int'(m_tsent));
    chk("tdata", int'(tdata), int'(m_tdata));
    chk("count", int'(count), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("isFinish", int'(isFinish), int'(m_fin));
    chk("errTimeout", int'(errTimeout), int'(m_err));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    check_all();
  endtask

  logic [WIDTH-1:0] got[$];
  int               fins;
  logic             prev;

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_tsent", int'(tsent), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_fin", int'(isFinish), 0);
    chk("rst_err", int'(errTimeout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single word 0xA5 with an immediate responder.
    push = 1'b1; data = 8'hA5; step();
    chk("t1_count", int'(count), 1);
    push = 1'b0; step();
    chk("t1_tsent", int'(tsent), 1);
    chk("t1_tdata", int'(tdata), 'hA5);
    trecieve = 1'b1; step();
    chk("t1_tsent_low", int'(tsent), 0);
    chk("t1_count0", int'(count), 0);
    trecieve = 1'b0; step();
    chk("t1_fin", int'(isFinish), 1);
    step();
    chk("t1_fin_end", int'(isFinish), 0);

    // Fill to DEPTH, overflow push ignored, drain in order.
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; data = WIDTH'(i); step();
    end
    chk("t2_full", int'(full), 1);
    chk("t2_count4", int'(count), 4);
    data = 8'h05; step();
    push = 1'b0;
    chk("t2_count_ovf", int'(count), 4);
    got.delete(); fins = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (tsent && !prev) got.push_back(tdata);
      prev = tsent;
      if (isFinish) fins++;
      trecieve = tsent;
      step();
    end
    chk("t2_nwords", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_word", int'(got[i]), i + 1);
    chk("t2_fins", fins, 1);
    chk("t2_count_end", int'(count), 0);

    // Acknowledge timeout.
    trecieve = 1'b0;
    push = 1'b1; data = 8'h3C; step();
    push = 1'b0; step();
    chk("t3_tsent", int'(tsent), 1);
    chk("t3_tdata", int'(tdata), 'h3C);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t3_hold", int'(tsent), 1);
    end
    step();
    chk("t3_drop", int'(tsent), 0);
    chk("t3_err", int'(errTimeout), 1);
    chk("t3_count", int'(count), 0);
    step();
    chk("t3_fin", int'(isFinish), 1);
    repeat (3) step();
    chk("t3_sticky", int'(errTimeout), 1);

    // Asynchronous reset with three words buffered and one in flight.
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; data = WIDTH'(8'h40 + i); step();
    end
    push = 1'b0; step();
    chk("t5_tsent", int'(tsent), 1);
    chk("t5_count", int'(count), 3);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_tsent", int'(tsent), 0);
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_err", int'(errTimeout), 0);
    chk("t5_rst_fin", int'(isFinish), 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("t5_no_fin", int'(isFinish), 0);

    // Receiver holds acknowledge high for several cycles.
    push = 1'b1; data = 8'h11; step();
    data = 8'h22; step();
    push = 1'b0;
    chk("t4_tdata1", int'(tdata), 'h11);
    trecieve = 1'b1; step();
    chk("t4_ack_low", int'(tsent), 0);
    chk("t4_count1", int'(count), 1);
    repeat (5) begin
      step();
      chk("t4_hold_low", int'(tsent), 0);
    end
    trecieve = 1'b0; step();
    chk("t4_no_fin", int'(isFinish), 0);
    step();
    chk("t4_tsent2", int'(tsent), 1);
    chk("t4_tdata2", int'(tdata), 'h22);
    trecieve = 1'b1; step();
    trecieve = 1'b0; step();
    chk("t4_fin", int'(isFinish), 1);

    // Randomised traffic with an erratic receiver and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      push = ($urandom_range(0, 9) < 4);
      data = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) trecieve = ~trecieve;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
